// File: rtl/axi_lite_pkg.sv
// rtl/axi_lite_pkg.sv - state encoding and shared constants for the AXI-lite master
package axi_lite_pkg;
  localparam int unsigned ADDR_W_DEF = 32;
  localparam int unsigned DATA_W_DEF = 32;
  localparam logic        BRESP_OK   = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    WR_REQ,
    WR_RESP,
    RD_REQ,
    RD_DATA
  } state_e;
endpackage

// File: rtl/axi_mst_watchdog.sv
// rtl/axi_mst_watchdog.sv - counts in-flight cycles and flags expiry of a stalled transaction
module axi_mst_watchdog #(
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_o
);
  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (enable_i) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = enable_i && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
endmodule

// File: rtl/axi_lite_master.sv
// rtl/axi_lite_master.sv - single-outstanding AXI-lite initiator turning commands into AW/W/B or AR/R
// Optional watchdog abort is built when AXI_MST_TIMEOUT_EN is defined.
module axi_lite_master
  import axi_lite_pkg::*;
#(
  parameter int unsigned ADDR_W         = ADDR_W_DEF,
  parameter int unsigned DATA_W         = DATA_W_DEF,
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic              aclk,
  input  logic              areset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic [ADDR_W-1:0] awaddr,
  output logic              awvalid,
  input  logic              awready,
  output logic [DATA_W-1:0] wdata,
  output logic              wvalid,
  input  logic              wready,
  input  logic              bvalid,
  input  logic              bresp,
  output logic              bready,
  output logic [ADDR_W-1:0] araddr,
  output logic              arvalid,
  input  logic              arready,
  input  logic [DATA_W-1:0] rdata,
  input  logic              rvalid,
  output logic              rready
);
  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                awvalid_q, awvalid_d;
  logic                wvalid_q, wvalid_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic                rsp_err_q, rsp_err_d;
  logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic                done;
  logic                wd_expired;

`ifdef AXI_MST_TIMEOUT_EN
  axi_mst_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk_i    (aclk),
    .rst_i    (areset),
    .clear_i  (state_q == IDLE),
    .enable_i (state_q != IDLE),
    .expired_o(wd_expired)
  );
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
  assign wd_expired         = 1'b0;
`endif

  assign done = ((state_q == WR_RESP) && bvalid) || ((state_q == RD_DATA) && rvalid);

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    awvalid_d   = awvalid_q;
    wvalid_d    = wvalid_q;
    rsp_valid_d = 1'b0;
    rsp_err_d   = 1'b0;
    rsp_rdata_d = '0;
    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          addr_d  = cmd_addr;
          wdata_d = cmd_wdata;
          if (cmd_write) begin
            state_d   = WR_REQ;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
          end else begin
            state_d = RD_REQ;
          end
        end
      end
      WR_REQ: begin
        // AW and W retire independently; leave once neither is still pending.
        if (awvalid_q && awready) awvalid_d = 1'b0;
        if (wvalid_q && wready)   wvalid_d  = 1'b0;
        if ((!awvalid_q || awready) && (!wvalid_q || wready)) state_d = WR_RESP;
      end
      WR_RESP: begin
        if (bvalid) begin
          rsp_valid_d = 1'b1;
          rsp_err_d   = (bresp != BRESP_OK);
          state_d     = IDLE;
        end
      end
      RD_REQ: begin
        if (arready) state_d = RD_DATA;
      end
      RD_DATA: begin
        if (rvalid) begin
          rsp_valid_d = 1'b1;
          rsp_rdata_d = rdata;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    // A real completion in the expiry cycle takes precedence over the abort.
    if (wd_expired && !done) begin
      state_d     = IDLE;
      awvalid_d   = 1'b0;
      wvalid_d    = 1'b0;
      rsp_valid_d = 1'b1;
      rsp_err_d   = 1'b1;
      rsp_rdata_d = '0;
    end
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      wdata_q     <= '0;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      awvalid_q   <= awvalid_d;
      wvalid_q    <= wvalid_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  assign cmd_ready = (state_q == IDLE);
  assign arvalid   = (state_q == RD_REQ);
  assign bready    = (state_q == WR_RESP);
  assign rready    = (state_q == RD_DATA);
  assign awvalid   = awvalid_q;
  assign wvalid    = wvalid_q;
  assign awaddr    = addr_q;
  assign araddr    = addr_q;
  assign wdata     = wdata_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_rdata = rsp_rdata_q;
endmodule

// File: tb/tb_axi_lite_master.sv
// tb/tb_axi_lite_master.sv - randomized scoreboard bench for axi_lite_master with a behavioural SRAM slave
`timescale 1ns/1ps
module tb_axi_lite_master;
  localparam int TMO = 16;

  logic        aclk = 1'b0;
  logic        areset = 1'b1;
  logic        cmd_valid = 1'b0, cmd_ready, cmd_write = 1'b0;
  logic [31:0] cmd_addr = '0, cmd_wdata = '0;
  logic        rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;
  logic [31:0] awaddr, wdata, araddr;
  logic        awvalid, wvalid, arvalid, bready, rready;
  logic        awready = 1'b0, wready = 1'b0, arready = 1'b0;
  logic        bvalid = 1'b0, bresp = 1'b0, rvalid = 1'b0;
  logic [31:0] rdata = '0;

  axi_lite_master #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(TMO)) dut (
    .aclk(aclk), .areset(areset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wvalid(wvalid), .wready(wready),
    .bvalid(bvalid), .bresp(bresp), .bready(bready),
    .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rvalid(rvalid), .rready(rready)
  );

  always #5 aclk = ~aclk;

  int cyc = 0;
  always @(posedge aclk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          cyc;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] model_mem[logic [31:0]];
  logic [31:0] slave_mem[logic [31:0]];
  int          n_vec = 0;
  int          n_err = 0;
  bit          mon_en = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_cmd_ready"}, cmd_ready, 1);
    chk({tag, "_rsp_valid"}, rsp_valid, 0);
    chk({tag, "_rsp_rdata"}, rsp_rdata, 0);
    chk({tag, "_rsp_err"}, rsp_err, 0);
    chk({tag, "_valids"}, {awvalid, wvalid, arvalid}, 0);
    chk({tag, "_readies"}, {bready, rready}, 0);
    chk({tag, "_awaddr"}, awaddr, 0);
    chk({tag, "_araddr"}, araddr, 0);
    chk({tag, "_wdata"}, wdata, 0);
  endtask

  // Scoreboard monitor: every response pulse must match the oldest expectation.
  always @(negedge aclk) begin
    if (mon_en && rsp_valid) begin
      exp_t e;
      if (sb.size() == 0) begin
        chk("rsp_unexpected", rsp_valid, 0);
      end else begin
        e = sb.pop_front();
        chk("rsp_rdata", rsp_rdata, e.rdata);
        chk("rsp_err", rsp_err, e.err);
        chk("rsp_cycle", cyc, e.cyc);
        chk("rsp_cmd_ready", cmd_ready, 1);
      end
    end
  end

  task automatic issue(input logic wr, input logic [31:0] a, input logic [31:0] d, output int acc);
    int g = 0;
    @(negedge aclk);
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a; cmd_wdata = d;
    while (!cmd_ready && g < 100) begin @(negedge aclk); g++; end
    chk("cmd_ready_wait", cmd_ready, 1);
    acc = cyc;
    @(posedge aclk); #1;
    cmd_valid = 1'b0; cmd_write = 1'($urandom); cmd_addr = $urandom; cmd_wdata = $urandom;
  endtask

  task automatic do_write(input logic [31:0] a, input logic [31:0] d,
                          input int awd, input int wd, input int bd, input logic br);
    int          acc, g;
    logic [31:0] s_awaddr, s_wdata;
    issue(1'b1, a, d, acc);
    if (br == 1'b1) model_mem[a] = d;
    sb.push_back('{rdata: 32'h0, err: (br != 1'b1), cyc: acc + 3 + ((awd > wd) ? awd : wd) + bd});
    @(negedge aclk);
    fork
      begin
        chk("awvalid_up", awvalid, 1);
        for (int i = 0; i < awd; i++) begin
          @(negedge aclk);
          chk("awvalid_hold", awvalid, 1);
          chk("awaddr_hold", awaddr, a);
        end
        chk("awaddr", awaddr, a);
        s_awaddr = awaddr;
        awready = 1'b1;
        @(posedge aclk); #1 awready = 1'b0;
        @(negedge aclk);
        chk("awvalid_drop", awvalid, 0);
      end
      begin
        chk("wvalid_up", wvalid, 1);
        for (int i = 0; i < wd; i++) begin
          @(negedge aclk);
          chk("wvalid_hold", wvalid, 1);
          chk("wdata_hold", wdata, d);
        end
        chk("wdata", wdata, d);
        s_wdata = wdata;
        wready = 1'b1;
        @(posedge aclk); #1 wready = 1'b0;
        @(negedge aclk);
        chk("wvalid_drop", wvalid, 0);
      end
    join
    repeat (bd) @(negedge aclk);
    bvalid = 1'b1; bresp = br;
    g = 0;
    while (!bready && g < 100) begin @(negedge aclk); g++; end
    chk("bready_wait", bready, 1);
    @(posedge aclk); #1;
    bvalid = 1'b0; bresp = 1'($urandom);
    if (br == 1'b1) slave_mem[s_awaddr] = s_wdata;
  endtask

  task automatic do_read(input logic [31:0] a, input int ard, input int rd);
    int          acc, g;
    logic [31:0] s_araddr;
    issue(1'b0, a, $urandom, acc);
    sb.push_back('{rdata: (model_mem.exists(a) ? model_mem[a] : 32'h0), err: 1'b0,
                   cyc: acc + 3 + ard + rd});
    @(negedge aclk);
    chk("arvalid_up", arvalid, 1);
    for (int i = 0; i < ard; i++) begin
      @(negedge aclk);
      chk("arvalid_hold", arvalid, 1);
      chk("araddr_hold", araddr, a);
    end
    chk("araddr", araddr, a);
    s_araddr = araddr;
    arready = 1'b1;
    @(posedge aclk); #1 arready = 1'b0;
    @(negedge aclk);
    chk("arvalid_drop", arvalid, 0);
    repeat (rd) @(negedge aclk);
    rvalid = 1'b1;
    rdata = slave_mem.exists(s_araddr) ? slave_mem[s_araddr] : 32'h0;
    g = 0;
    while (!rready && g < 100) begin @(negedge aclk); g++; end
    chk("rready_wait", rready, 1);
    @(posedge aclk); #1;
    rvalid = 1'b0; rdata = $urandom;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: actual=running required=finished (cycle %0d)", cyc);
    $fatal(1);
  end

  initial begin
    int acc, g;
    areset = 1'b1;
    repeat (3) @(posedge aclk);
    @(negedge aclk);
    check_idle_outputs("reset");
    areset = 1'b0;
    mon_en = 1'b1;

    do_write(32'h0000_0010, 32'hDEAD_BEEF, 0, 0, 0, 1'b1);
    do_read (32'h0000_0010, 0, 0);
    do_write(32'h0000_0014, 32'h1234_5678, 0, 3, 0, 1'b1);
    do_write(32'h0000_0018, 32'hCAFE_F00D, 0, 0, 1, 1'b0);
    do_read (32'h0000_0018, 0, 1);
    do_write(32'h0000_001C, 32'h0BAD_F00D, 2, 0, 0, 1'b1);
    do_read (32'h0000_0014, 2, 2);

    // Reset while a read address is still waiting for arready.
    issue(1'b0, 32'h0000_0014, 32'h0, acc);
    @(negedge aclk);
    chk("rst_arvalid_pending", arvalid, 1);
    @(negedge aclk);
    areset = 1'b1;
    @(posedge aclk); #1 areset = 1'b0;
    @(negedge aclk);
    check_idle_outputs("midreset");
    do_read(32'h0000_0010, 1, 0);

`ifdef AXI_MST_TIMEOUT_EN
    issue(1'b0, 32'h0000_0018, 32'h0, acc);
    sb.push_back('{rdata: 32'h0, err: 1'b1, cyc: acc + TMO + 1});
    while (cyc < acc + TMO) @(negedge aclk);
    chk("tmo_arvalid_held", arvalid, 1);
    @(negedge aclk);
    chk("tmo_arvalid_drop", arvalid, 0);
    chk("tmo_cmd_ready", cmd_ready, 1);
    do_read(32'h0000_0010, 0, 0);
`endif

    for (int n = 0; n < 40; n++) begin
      logic [31:0] a;
      a = 32'h10 + 32'(4 * $urandom_range(0, 3));
      if ($urandom_range(0, 1) == 1)
        do_write(a, $urandom, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                 ($urandom_range(0, 3) != 0));
      else
        do_read(a, $urandom_range(0, 3), $urandom_range(0, 3));
    end

    g = 0;
    while (sb.size() != 0 && g < 200) begin @(negedge aclk); g++; end
    @(negedge aclk);
    chk("sb_drained", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
